int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Vectored interrupt controller/arbiter sharing the core's single interrupt entry between NSRC sources (push-button, timer, UART, ...).
- Detects rising edges, keeps per-source pending and mask bits, and picks the highest-priority request.
- Drives a request/acknowledge handshake with the instruction decoder and tracks the in-service state until RETI.
- Sits between the peripherals and ID; ID forwards int_vector to the PC.

Parameters:
- NSRC, 4, number of interrupt sources; index 0 has the highest priority.
- VEC_BASE, 8'h02, vector of source 0.
- VEC_STEP, 8'h02, vector spacing between consecutive sources.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next clk edge).
- src  in  NSRC  raw interrupt lines, already synchronised; rising-edge triggered.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NSRC  new mask value; 1 = source enabled.
- gie_set  in  1  SEI: set the global enable.
- gie_clr  in  1  CLI: clear the global enable.
- irq_ack  in  1  ID has taken the vector (one-cycle pulse).
- reti  in  1  RETI executed (one-cycle pulse).
- irq  out  1  interrupt request to ID.
- int_vector  out  8  vector of the request being presented.
- in_service  out  1  a handler is active.
- pending  out  NSRC  pending flags, for status reads.

Behaviour:
- Reset: irq=0, int_vector=0, in_service=0, pending=0, mask=0, gie=0, FSM=IDLE, edge history=0.
- Edge detection: src_prev registers src every cycle.
  - pending[i] is set when src[i]=1, src_prev[i]=0 and mask[i]=1.
  - gie has no effect on capture.
  - Edges on masked sources are discarded, not latched.
- Mask: mask_we loads mask_wdata. Clearing a mask bit also clears that pending bit in the same cycle.
- Global enable:
  - gie_set and gie_clr together: set wins.
  - Auto-clear on irq_ack and auto-set on reti take priority over both strobes in the same cycle.
- Arbitration: the winner is the lowest index i with pending[i]=1. Vector = VEC_BASE + i*VEC_STEP, 8-bit, wraps mod 256.
- FSM states:
  - IDLE → REQ when gie=1 and pending≠0. Latches the winner index and vector; irq=1 from the next cycle.
  - REQ: irq and int_vector are held stable until irq_ack, with no re-arbitration. Priority is checked only in IDLE, so a higher-priority edge arriving in REQ stays pending. gie_clr and mask changes do not retract an issued request.
  - REQ → SERVICE on irq_ack: pending[winner] cleared, gie cleared, irq=0, int_vector=0, in_service=1.
  - SERVICE → IDLE on reti: gie set, in_service=0. Leftover pending sources are re-arbitrated in IDLE the following cycle.
- Latency: minimum 1 cycle from a pending bit (with gie=1) to irq=1.
- Simultaneous events:
  - A new edge on the winner's source in the same cycle as irq_ack: set wins, and that source stays pending.
  - reti outside SERVICE is ignored.
  - irq_ack outside REQ is ignored.
- Reset mid-operation: rst=0 in any state returns the block to IDLE with all reset values; in-flight requests are lost.

Optional Feature:
- INT_NEST_EN defined: one level of preemption.
  - In SERVICE, a pending source with strictly higher priority than the active one raises irq again (state REQ_NEST), regardless of gie.
  - On irq_ack the active index and vector are pushed to a one-entry save register and in_service stays 1.
  - The first reti restores the saved index and returns to SERVICE; the second reti returns to IDLE.
  - Deeper preemption is not allowed.
- INT_NEST_EN undefined: no preemption; SERVICE waits only for reti.

Decomposition:
- Package int_pkg holds:
  - the FSM state enum (IDLE, REQ, SERVICE, REQ_NEST);
  - default NSRC/VEC_BASE/VEC_STEP constants;
  - a function idx_to_vec.
- One sub-module, int_prio_enc: a combinational lowest-index-first encoder that outputs valid and index for the pending and mask vectors.

Test Plan:
- gie=1, mask=4'hF, rising edge on src[1] → irq=1 and int_vector=8'h04 one cycle after pending[1]=1. irq_ack → irq=0, in_service=1, pending[1]=0, gie=0. reti → in_service=0.
- Edges on src[2] and src[0] in the same cycle, gie=1 → vector 8'h02 first. After reti → vector 8'h06.
- gie=0, edge on src[0] → pending[0]=1, irq=0. gie_set → irq=1 with vector 8'h02.
- mask=4'hE, edge on src[0] → pending stays 0. Then mask_we clears bit 1 while pending[1]=1 → pending[1]=0.
- Request in REQ with irq=1, then rst=0 for one cycle → irq=0, pending=0, mask=0, gie=0. A later edge yields no irq until mask and gie are set again.
- INT_NEST_EN: while servicing src[2], edge on src[0] → irq with 8'h02. Ack, then reti → in_service=1 with src[2] restored. Second reti → in_service=0.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
// Contents: FSM state enum, default configuration constants, vector helper.
package int_pkg;

   localparam int unsigned NSRC_DEF     = 4;
   localparam int unsigned VEC_W        = 8;
   localparam logic [7:0]  VEC_BASE_DEF = 8'h02;
   localparam logic [7:0]  VEC_STEP_DEF = 8'h02;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      SERVICE  = 2'd2,
      REQ_NEST = 2'd3
   } int_state_e;

   // Vector of source idx: base + idx*step, wrapping mod 256.
   function automatic logic [7:0] idx_to_vec(input logic [7:0] idx,
                                             input logic [7:0] base,
                                             input logic [7:0] step);
      logic [15:0] prod;
      prod = 16'(idx) * 16'(step);
      return 8'(base + prod[7:0]);
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its surroundings (peripherals + ID).
// master: peripheral/decoder side (drives src, mask, gie strobes, ack, reti)
// slave : controller side (drives irq, int_vector, in_service, pending)
interface int_ctrl_if #(
   parameter int unsigned NSRC = int_pkg::NSRC_DEF
);
   logic [NSRC-1:0] src;
   logic            mask_we;
   logic [NSRC-1:0] mask_wdata;
   logic            gie_set;
   logic            gie_clr;
   logic            irq_ack;
   logic            reti;
   logic            irq;
   logic [7:0]      int_vector;
   logic            in_service;
   logic [NSRC-1:0] pending;

   modport master (
      output src, mask_we, mask_wdata, gie_set, gie_clr, irq_ack, reti,
      input  irq, int_vector, in_service, pending
   );

   modport slave (
      input  src, mask_we, mask_wdata, gie_set, gie_clr, irq_ack, reti,
      output irq, int_vector, in_service, pending
   );
endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over enabled pending sources.
// Ports: pending, mask (NSRC) in; valid_c (any request), idx_c (winner) out.
module int_prio_enc #(
   parameter int unsigned NSRC = 4,
   parameter int unsigned IDXW = 2
) (
   input  logic [NSRC-1:0] pending,
   input  logic [NSRC-1:0] mask,
   output logic            valid_c,
   output logic [IDXW-1:0] idx_c
);

   logic [NSRC-1:0] req_c;

   // Scan high to low so the lowest set index is the last assignment.
   always_comb begin
      req_c   = pending & mask;
      valid_c = 1'b0;
      idx_c   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_c[i]) begin
            valid_c = 1'b1;
            idx_c   = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge capture, mask, global enable, priority
// arbitration and request/ack/in-service tracking for the core's single
// interrupt entry.
// Ports: clk, rst (sync, active-low), bus (int_ctrl_if.slave: src, mask_we,
//        mask_wdata, gie_set, gie_clr, irq_ack, reti in; irq, int_vector,
//        in_service, pending out).
// Build option: INT_NEST_EN enables one level of preemption in SERVICE.
module int_ctrl
   import int_pkg::*;
#(
   parameter int unsigned NSRC     = NSRC_DEF,
   parameter logic [7:0]  VEC_BASE = VEC_BASE_DEF,
   parameter logic [7:0]  VEC_STEP = VEC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   int_ctrl_if.slave   bus
);

   localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

   int_state_e      state_q, state_d;
   logic [NSRC-1:0] src_prev_q, src_prev_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic            gie_q, gie_d;
   logic            irq_q, irq_d;
   logic [7:0]      vec_q, vec_d;
   logic            insvc_q, insvc_d;
   logic [IDXW-1:0] req_idx_q, req_idx_d;
`ifdef INT_NEST_EN
   logic [IDXW-1:0] act_idx_q, act_idx_d;
   logic [IDXW-1:0] save_idx_q, save_idx_d;
   logic            nested_q, nested_d;
`endif

   logic            enc_valid_c;
   logic [IDXW-1:0] enc_idx_c;
   logic            ack_take_c;
   logic            reti_take_c;
   logic            reti_idle_c;
   logic            preempt_c;
   logic [NSRC-1:0] edge_c;
   logic [NSRC-1:0] ack_clr_c;

   int_prio_enc #(
      .NSRC (NSRC),
      .IDXW (IDXW)
   ) u_prio_enc (
      .pending (pend_q),
      .mask    (mask_q),
      .valid_c (enc_valid_c),
      .idx_c   (enc_idx_c)
   );

   // Handshake qualifiers: strobes outside their state are ignored.
   always_comb begin
      ack_take_c  = bus.irq_ack && ((state_q == REQ) || (state_q == REQ_NEST));
      reti_take_c = bus.reti && (state_q == SERVICE);
`ifdef INT_NEST_EN
      reti_idle_c = reti_take_c && !nested_q;
      preempt_c   = (state_q == SERVICE) && !nested_q && enc_valid_c &&
                    (enc_idx_c < act_idx_q);
`else
      reti_idle_c = reti_take_c;
      preempt_c   = 1'b0;
`endif
   end

   // Edge capture, mask register, pending flags and global enable.
   always_comb begin
      src_prev_d = bus.src;
      edge_c     = bus.src & ~src_prev_q & mask_q;
      ack_clr_c  = ack_take_c ? (NSRC'(1) << req_idx_q) : '0;
      // A fresh edge on the acknowledged source survives the ack clear.
      pend_d     = (pend_q & ~ack_clr_c) | edge_c;
      mask_d     = mask_q;
      if (bus.mask_we) begin
         mask_d = bus.mask_wdata;
         pend_d = pend_d & bus.mask_wdata;
      end
      gie_d = gie_q;
      if (bus.gie_clr) gie_d = 1'b0;
      if (bus.gie_set) gie_d = 1'b1;
      if (ack_take_c)  gie_d = 1'b0;
      if (reti_idle_c) gie_d = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (gie_q && enc_valid_c) state_d = REQ;
         REQ:      if (ack_take_c) state_d = SERVICE;
         SERVICE: begin
            if (reti_idle_c)    state_d = IDLE;
            else if (preempt_c) state_d = REQ_NEST;
         end
`ifdef INT_NEST_EN
         REQ_NEST: if (ack_take_c) state_d = SERVICE;
`endif
         default:  state_d = IDLE;
      endcase
   end

   // FSM output / request-tracking logic (feeds registered outputs).
   always_comb begin
      irq_d      = irq_q;
      vec_d      = vec_q;
      insvc_d    = insvc_q;
      req_idx_d  = req_idx_q;
`ifdef INT_NEST_EN
      act_idx_d  = act_idx_q;
      save_idx_d = save_idx_q;
      nested_d   = nested_q;
`endif
      case (state_q)
         IDLE: begin
            if (gie_q && enc_valid_c) begin
               irq_d     = 1'b1;
               req_idx_d = enc_idx_c;
               vec_d     = idx_to_vec(8'(enc_idx_c), VEC_BASE, VEC_STEP);
            end
         end
         REQ, REQ_NEST: begin
            if (ack_take_c) begin
               irq_d   = 1'b0;
               vec_d   = 8'h00;
               insvc_d = 1'b1;
`ifdef INT_NEST_EN
               act_idx_d = req_idx_q;
               if (state_q == REQ_NEST) begin
                  save_idx_d = act_idx_q;
                  nested_d   = 1'b1;
               end
`endif
            end
         end
         SERVICE: begin
            if (reti_idle_c) begin
               insvc_d = 1'b0;
`ifdef INT_NEST_EN
            end else if (reti_take_c) begin
               // Nested handler done: resume the preempted one.
               act_idx_d = save_idx_q;
               nested_d  = 1'b0;
`endif
            end else if (preempt_c) begin
               irq_d     = 1'b1;
               req_idx_d = enc_idx_c;
               vec_d     = idx_to_vec(8'(enc_idx_c), VEC_BASE, VEC_STEP);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         src_prev_q <= '0;
         mask_q     <= '0;
         pend_q     <= '0;
         gie_q      <= 1'b0;
         irq_q      <= 1'b0;
         vec_q      <= 8'h00;
         insvc_q    <= 1'b0;
         req_idx_q  <= '0;
`ifdef INT_NEST_EN
         act_idx_q  <= '0;
         save_idx_q <= '0;
         nested_q   <= 1'b0;
`endif
      end else begin
         src_prev_q <= src_prev_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         gie_q      <= gie_d;
         irq_q      <= irq_d;
         vec_q      <= vec_d;
         insvc_q    <= insvc_d;
         req_idx_q  <= req_idx_d;
`ifdef INT_NEST_EN
         act_idx_q  <= act_idx_d;
         save_idx_q <= save_idx_d;
         nested_q   <= nested_d;
`endif
      end
   end

   assign bus.irq        = irq_q;
   assign bus.int_vector = vec_q;
   assign bus.in_service = insvc_q;
   assign bus.pending    = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model.
module tb_int_ctrl;
   import int_pkg::*;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int_ctrl_if #(.NSRC(N)) bus ();

   int_ctrl #(
      .NSRC     (N),
      .VEC_BASE (8'h02),
      .VEC_STEP (8'h02)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 request, 2 servicing, 3 nested request.
   bit [N-1:0] m_pend, m_mask, m_prev;
   bit         m_gie, m_irq, m_insvc, m_nested;
   bit [7:0]   m_vec;
   int         m_ph, m_req, m_act, m_saved;

   function automatic int winner(input bit [N-1:0] p, input bit [N-1:0] m);
      for (int i = 0; i < N; i++) if (p[i] && m[i]) return i;
      return -1;
   endfunction

   function automatic bit [7:0] vec_of(input int i);
      return 8'((2 + 2 * i) % 256);
   endfunction

   task automatic model_step();
      bit [N-1:0] e, p;
      bit g, ack_t, reti_t;
      int w;
      if (!rst) begin
         m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 0; m_irq = 0;
         m_insvc = 0; m_nested = 0; m_vec = 0; m_ph = 0; m_req = 0; m_act = 0; m_saved = 0;
         return;
      end
      e      = bus.src & ~m_prev & m_mask;
      ack_t  = bus.irq_ack && (m_ph == 1 || m_ph == 3);
      reti_t = bus.reti && m_ph == 2;
      p = m_pend;
      if (ack_t) p[m_req] = 1'b0;
      p = p | e;
      if (bus.mask_we) p = p & bus.mask_wdata;
      g = m_gie;
      if (bus.gie_clr) g = 0;
      if (bus.gie_set) g = 1;
      if (ack_t) g = 0;
      if (reti_t && !m_nested) g = 1;
      w = winner(m_pend, m_mask);
      case (m_ph)
         0: if (m_gie && w >= 0) begin
               m_ph = 1; m_req = w; m_irq = 1; m_vec = vec_of(w);
            end
         1, 3: if (ack_t) begin
               if (m_ph == 3) begin m_saved = m_act; m_nested = 1; end
               m_act = m_req; m_ph = 2; m_irq = 0; m_vec = 0; m_insvc = 1;
            end
         2: begin
            if (reti_t) begin
               if (m_nested) begin m_act = m_saved; m_nested = 0; end
               else begin m_ph = 0; m_insvc = 0; end
            end
`ifdef INT_NEST_EN
            else if (!m_nested && w >= 0 && w < m_act) begin
               m_ph = 3; m_req = w; m_irq = 1; m_vec = vec_of(w);
            end
`endif
         end
         default: ;
      endcase
      m_pend = p;
      m_gie  = g;
      if (bus.mask_we) m_mask = bus.mask_wdata;
      m_prev = bus.src;
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("irq",        32'(bus.irq),        32'(m_irq));
      chk("int_vector", 32'(bus.int_vector), 32'(m_vec));
      chk("in_service", 32'(bus.in_service), 32'(m_insvc));
      chk("pending",    32'(bus.pending),    32'(m_pend));
   endtask

   task automatic idle_inputs();
      bus.mask_we = 0; bus.gie_set = 0; bus.gie_clr = 0;
      bus.irq_ack = 0; bus.reti = 0;
   endtask

   initial begin
      rst = 0;
      bus.src = '0; bus.mask_wdata = '0;
      idle_inputs();
      cycle();
      chk("reset_irq", 32'(bus.irq), 32'd0);
      chk("reset_pending", 32'(bus.pending), 32'd0);
      rst = 1;

      // Basic request on src[1].
      bus.mask_we = 1; bus.mask_wdata = 4'hF; bus.gie_set = 1;
      cycle();
      idle_inputs();
      bus.src = 4'b0010;
      cycle();
      chk("p1_pending", 32'(bus.pending), 32'h2);
      cycle();
      chk("p1_irq", 32'(bus.irq), 32'd1);
      chk("p1_vec", 32'(bus.int_vector), 32'h04);
      bus.irq_ack = 1;
      cycle();
      bus.irq_ack = 0;
      chk("p1_insvc", 32'(bus.in_service), 32'd1);
      chk("p1_irq_low", 32'(bus.irq), 32'd0);
      bus.reti = 1;
      cycle();
      bus.reti = 0;
      chk("p1_reti", 32'(bus.in_service), 32'd0);

      // Simultaneous edges on src[2] and src[0]: 0 first, then 2.
      bus.src = 4'b0000;
      cycle();
      bus.src = 4'b0101;
      cycle();
      cycle();
      chk("p2_vec_first", 32'(bus.int_vector), 32'h02);
      bus.irq_ack = 1; cycle(); bus.irq_ack = 0;
      bus.reti = 1; cycle(); bus.reti = 0;
      cycle();
      chk("p2_vec_second", 32'(bus.int_vector), 32'h06);
      bus.irq_ack = 1; cycle(); bus.irq_ack = 0;
      bus.reti = 1; cycle(); bus.reti = 0;

      // Masked edge discarded.
      bus.src = 4'b0000; bus.mask_we = 1; bus.mask_wdata = 4'hE; cycle();
      idle_inputs(); bus.src = 4'b0001; cycle();
      chk("p4_masked", 32'(bus.pending[0]), 32'd0);

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         rst            = ($urandom_range(0, 199) != 0);
         bus.src        = N'($urandom);
         bus.mask_we    = ($urandom_range(0, 15) == 0);
         bus.mask_wdata = ($urandom_range(0, 1) != 0) ? N'(4'hF) : N'($urandom);
         bus.gie_set    = ($urandom_range(0, 5) == 0);
         bus.gie_clr    = ($urandom_range(0, 9) == 0);
         bus.irq_ack    = ($urandom_range(0, 2) == 0);
         bus.reti       = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
